// File: rtl/nv_csa_tree_acc.sv
// Carry-save 3:2 reduction tree over NUM_INPUTS operands feeding a carry-save burst accumulator.
// Latency: PIPE_STAGES tree registers plus one accumulator/output register.
// Backpressure: a single global enable (!out_pvld | out_prdy) freezes every stage; in_prdy = enable.
module nv_csa_tree_acc #(
  parameter int NUM_INPUTS  = 8,
  parameter int IN_W        = 8,
  parameter int OUT_W       = 19,
  parameter int PIPE_STAGES = 2
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rst,
  input  logic                       in_pvld,
  output logic                       in_prdy,
  input  logic [NUM_INPUTS*IN_W-1:0] in_data,
  input  logic                       in_signed,
  input  logic                       in_first,
  input  logic                       in_last,
  output logic                       out_pvld,
  input  logic                       out_prdy,
  output logic [OUT_W-1:0]           out_sum0,
  output logic [OUT_W-1:0]           out_sum1,
  output logic [OUT_W-1:0]           out_total
);

  // Operand count present at the output of tree level lvl (level 0 = raw operands).
  function automatic int n_at(input int lvl);
    int n;
    n = NUM_INPUTS;
    for (int i = 0; i < lvl; i++) n = n - n / 3;
    return n;
  endfunction

  // Number of 3:2 levels needed to reach two words.
  function automatic int level_count();
    int n;
    int c;
    n = NUM_INPUTS;
    c = 0;
    while (n > 2) begin
      n = n - n / 3;
      c = c + 1;
    end
    return c;
  endfunction

  localparam int L = level_count();

  // A register follows level floor(j*L/PIPE_STAGES) for j = 1..PIPE_STAGES.
  function automatic logic is_reg(input int lvl);
    logic r;
    r = 1'b0;
    for (int j = 1; j <= PIPE_STAGES; j++) begin
      if ((j * L) / PIPE_STAGES == lvl) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] maj3(input logic [OUT_W-1:0] a,
                                            input logic [OUT_W-1:0] b,
                                            input logic [OUT_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic en;
  assign en      = !out_pvld | out_prdy;
  assign in_prdy = en;

  // Each level exposes c_* (combinational result) and q_* (after the optional stage register).
  for (genvar k = 0; k <= L; k++) begin : g_lvl
    localparam int NO = n_at(k);
    logic [OUT_W-1:0] c_w [NO];
    logic [OUT_W-1:0] q_w [NO];
    logic             c_v, c_f, c_l;
    logic             q_v, q_f, q_l;

    if (k == 0) begin : g_src
      for (genvar i = 0; i < NO; i++) begin : g_ext
        logic [IN_W-1:0] op;
        assign op     = in_data[i*IN_W +: IN_W];
        assign c_w[i] = {{(OUT_W-IN_W){in_signed & op[IN_W-1]}}, op};
      end
      assign c_v = in_pvld & en;
      assign c_f = in_first;
      assign c_l = in_last;
    end else begin : g_csa
      localparam int NI = n_at(k-1);
      localparam int T  = NI / 3;
      for (genvar t = 0; t < T; t++) begin : g_fa
        logic [OUT_W-1:0] a, b, c;
        assign a          = g_lvl[k-1].q_w[3*t];
        assign b          = g_lvl[k-1].q_w[3*t+1];
        assign c          = g_lvl[k-1].q_w[3*t+2];
        assign c_w[2*t]   = a ^ b ^ c;
        assign c_w[2*t+1] = maj3(a, b, c) << 1;
      end
      // Leftover operands that did not form a full triple skip this level.
      for (genvar r = 0; r < NI - 3*T; r++) begin : g_pass
        assign c_w[2*T+r] = g_lvl[k-1].q_w[3*T+r];
      end
      assign c_v = g_lvl[k-1].q_v;
      assign c_f = g_lvl[k-1].q_f;
      assign c_l = g_lvl[k-1].q_l;
    end

    if (is_reg(k)) begin : g_reg
      // Stage register: advances only with the global enable; only the valid is reset.
      always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) q_v <= 1'b0;
        else if (en)        q_v <= c_v;
        if (en) begin
          q_w <= c_w;
          q_f <= c_f;
          q_l <= c_l;
        end
      end
    end else begin : g_wire
      for (genvar i = 0; i < NO; i++) begin : g_w
        assign q_w[i] = c_w[i];
      end
      assign q_v = c_v;
      assign q_f = c_f;
      assign q_l = c_l;
    end
  end

  // Accumulator: 4:2 compression of the two tree words with the two accumulator words.
  logic [OUT_W-1:0] acc0, acc1;
  logic [OUT_W-1:0] t0, t1, a0, a1, s1, c1, s2, c2;
  logic             acc_v, acc_f, acc_l;

  assign t0    = g_lvl[L].q_w[0];
  assign t1    = g_lvl[L].q_w[1];
  assign acc_v = g_lvl[L].q_v;
  assign acc_f = g_lvl[L].q_f;
  assign acc_l = g_lvl[L].q_l;

  // A first beat starts from zero instead of the previous burst's accumulator.
  assign a0 = acc_f ? '0 : acc0;
  assign a1 = acc_f ? '0 : acc1;
  assign s1 = t0 ^ t1 ^ a0;
  assign c1 = maj3(t0, t1, a0) << 1;
  assign s2 = s1 ^ c1 ^ a1;
  assign c2 = maj3(s1, c1, a1) << 1;

  // Accumulate every valid beat; publish on last, otherwise drop a consumed result.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      acc0     <= '0;
      acc1     <= '0;
      out_sum0 <= '0;
      out_sum1 <= '0;
      out_pvld <= 1'b0;
    end else if (en) begin
      if (acc_v) begin
        acc0 <= s2;
        acc1 <= c2;
      end
      if (acc_v && acc_l) begin
        out_sum0 <= s2;
        out_sum1 <= c2;
        out_pvld <= 1'b1;
      end else begin
        out_pvld <= 1'b0;
      end
    end
  end

  assign out_total = out_sum0 + out_sum1;

endmodule

// File: tb/tb_nv_csa_tree_acc.sv
// Bench for nv_csa_tree_acc: directed cases plus a random stream against a burst-sum model.
// Two instances: default widths with 2 stages, and a 10-bit result with a register per level.
module tb_nv_csa_tree_acc;
  localparam int NI = 8;
  localparam int IW = 8;
  localparam int W  = 19;
  localparam int P  = 2;
  localparam int W2 = 10;
  localparam int P2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_pvld, in_prdy, in_signed, in_first, in_last;
  logic [NI*IW-1:0] in_data;
  logic             out_pvld, out_prdy;
  logic [W-1:0]     out_sum0, out_sum1, out_total;

  logic             b_pvld, b_prdy, b_signed, b_first, b_last;
  logic [NI*IW-1:0] b_data;
  logic             b_opvld, b_oprdy;
  logic [W2-1:0]    b_sum0, b_sum1, b_total;

  nv_csa_tree_acc #(.NUM_INPUTS(NI), .IN_W(IW), .OUT_W(W), .PIPE_STAGES(P)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .in_pvld(in_pvld), .in_prdy(in_prdy), .in_data(in_data), .in_signed(in_signed),
    .in_first(in_first), .in_last(in_last),
    .out_pvld(out_pvld), .out_prdy(out_prdy),
    .out_sum0(out_sum0), .out_sum1(out_sum1), .out_total(out_total)
  );

  nv_csa_tree_acc #(.NUM_INPUTS(NI), .IN_W(IW), .OUT_W(W2), .PIPE_STAGES(P2)) dut_w10 (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .in_pvld(b_pvld), .in_prdy(b_prdy), .in_data(b_data), .in_signed(b_signed),
    .in_first(b_first), .in_last(b_last),
    .out_pvld(b_opvld), .out_prdy(b_oprdy),
    .out_sum0(b_sum0), .out_sum1(b_sum1), .out_total(b_total)
  );

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_acc;
  int           stall_left;
  bit           rand_prdy;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Plain integer sum of one beat's operands.
  function automatic longint beat_sum(input logic [NI*IW-1:0] d, input logic s);
    longint       t;
    logic [IW-1:0] op;
    t = 0;
    for (int i = 0; i < NI; i++) begin
      op = d[i*IW +: IW];
      if (s && op[IW-1]) t += longint'(op) - (longint'(1) << IW);
      else               t += longint'(op);
    end
    return t;
  endfunction

  // Burst model: first restarts from zero, last publishes the running total.
  task automatic model_accept(input logic [NI*IW-1:0] d, input logic s, input logic f, input logic l);
    longint bs;
    bs = beat_sum(d, s);
    if (f) m_acc = '0;
    m_acc = m_acc + bs[W-1:0];
    if (l) exp_q.push_back(m_acc);
  endtask

  task automatic drive_prdy();
    if (stall_left > 0) begin
      stall_left--;
      out_prdy = 1'b0;
    end else if (rand_prdy) begin
      out_prdy = ($urandom_range(0, 3) != 0);
    end else begin
      out_prdy = 1'b1;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the beat was taken.
  task automatic send_beat(input logic [NI*IW-1:0] d, input logic s, input logic f, input logic l);
    int guard;
    guard = 0;
    in_pvld = 1'b1; in_data = d; in_signed = s; in_first = f; in_last = l;
    drive_prdy();
    #1;
    while (!in_prdy && guard < 200) begin
      @(negedge clk);
      drive_prdy();
      #1;
      guard++;
    end
    if (in_prdy) model_accept(d, s, f, l);
    else chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_pvld = 1'b0;
  endtask

  task automatic idle();
    in_pvld = 1'b0;
    drive_prdy();
    @(negedge clk);
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] exp, input int lat);
    int n;
    n = 0;
    in_pvld = 1'b0;
    out_prdy = 1'b1;
    #1;
    while (!out_pvld && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_latency"}, n + 1, lat);
    chk(name, out_total, exp);
    @(negedge clk);
  endtask

  task automatic send10(input logic [NI*IW-1:0] d, input logic s, input logic f, input logic l);
    b_pvld = 1'b1; b_data = d; b_signed = s; b_first = f; b_last = l;
    #1;
    chk("w10_in_prdy", b_prdy, 1);
    @(negedge clk);
    b_pvld = 1'b0;
  endtask

  task automatic wait10(input string name, input logic [W2-1:0] exp, input int lat);
    int            n;
    logic [W2-1:0] ws;
    n = 0;
    #1;
    while (!b_opvld && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    ws = b_sum0 + b_sum1;
    chk({name, "_latency"}, n + 1, lat);
    chk(name, b_total, exp);
    chk({name, "_words"}, ws, exp);
    @(negedge clk);
  endtask

  function automatic logic [NI*IW-1:0] rand_data();
    logic [NI*IW-1:0] d;
    int               mode;
    mode = $urandom_range(0, 7);
    d = {$urandom, $urandom};
    if (mode == 0) d = {NI{8'hFF}};
    if (mode == 1) d = {NI{8'h80}};
    return d;
  endfunction

  // Monitor: enable/ready relation every cycle, and in-order result scoreboard.
  initial begin
    logic [W-1:0] e, ws;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        chk("in_prdy_vs_enable", in_prdy, (!out_pvld || out_prdy));
        if (out_pvld && out_prdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got total %0d, expected no result", out_total);
          end else begin
            e  = exp_q.pop_front();
            ws = out_sum0 + out_sum1;
            chk("result_total", out_total, e);
            chk("result_words", ws, e);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [NI*IW-1:0] d, d1, d2;
    longint           t;
    logic [W-1:0]     e5;
    int               g;

    rst = 1'b1;
    in_pvld = 1'b0; in_data = '0; in_signed = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_prdy = 1'b1;
    b_pvld = 1'b0; b_data = '0; b_signed = 1'b0; b_first = 1'b0; b_last = 1'b0; b_oprdy = 1'b1;
    stall_left = 0; rand_prdy = 1'b0; m_acc = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_pvld", out_pvld, 0);
    chk("reset_sum0", out_sum0, 0);
    chk("reset_sum1", out_sum1, 0);
    chk("reset_in_prdy", in_prdy, 1);
    chk("reset_w10_out_pvld", b_opvld, 0);
    @(negedge clk);

    send_beat({NI{8'hFF}}, 1'b0, 1'b1, 1'b1);
    wait_result("unsigned_all_ff", 19'h007F8, P + 1);

    send_beat({NI{8'h80}}, 1'b1, 1'b1, 1'b1);
    wait_result("signed_all_min", 19'h7FC00, P + 1);

    for (int i = 0; i < NI; i++) d[i*IW +: IW] = 8'(i + 1);
    for (int b = 0; b < 4; b++) send_beat(d, 1'b0, b == 0, b == 3);
    wait_result("burst_of_four", 144, P + 1);

    // Stream of short bursts with a five-cycle output stall in the middle.
    for (int i = 0; i < 30; i++) begin
      if (i == 6) stall_left = 5;
      send_beat(rand_data(), 1'(i % 2), (i % 3) == 0, (i % 3) == 2);
    end
    repeat (P + 4) idle();

    // Reset in the middle of a burst with another result still in flight.
    send_beat(rand_data(), 1'b0, 1'b1, 1'b0);
    send_beat(rand_data(), 1'b1, 1'b0, 1'b0);
    send_beat(rand_data(), 1'b0, 1'b1, 1'b1);
    send_beat(rand_data(), 1'b0, 1'b1, 1'b0);
    in_pvld = 1'b0;
    out_prdy = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    m_acc = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_out_pvld", out_pvld, 0);
    chk("midreset_sum0", out_sum0, 0);
    chk("midreset_sum1", out_sum1, 0);
    chk("midreset_in_prdy", in_prdy, 1);
    @(negedge clk);
    d1 = rand_data();
    d2 = rand_data();
    t  = beat_sum(d1, 1'b0) + beat_sum(d2, 1'b1);
    e5 = t[W-1:0];
    send_beat(d1, 1'b0, 1'b0, 1'b0);
    send_beat(d2, 1'b1, 1'b0, 1'b1);
    wait_result("after_reset_no_first", e5, P + 1);

    // Narrow result: wrap modulo 2^10, one register per tree level.
    send10({NI{8'hFF}}, 1'b0, 1'b1, 1'b0);
    send10({NI{8'hFF}}, 1'b0, 1'b0, 1'b1);
    wait10("w10_wrap", 10'd1008, P2 + 1);
    send10({NI{8'h80}}, 1'b1, 1'b1, 1'b1);
    wait10("w10_signed_min", 10'd0, P2 + 1);
    send10({NI{8'h80}}, 1'b0, 1'b1, 1'b0);
    send10({NI{8'hFF}}, 1'b1, 1'b0, 1'b1);
    wait10("w10_mixed_sign", 10'd1016, P2 + 1);

    // Random stream with random output backpressure and occasional long stalls.
    rand_prdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) stall_left = 5;
      if ($urandom_range(0, 4) == 0) idle();
      else send_beat(rand_data(), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    rand_prdy = 1'b0;
    stall_left = 0;
    g = 0;
    while (exp_q.size() > 0 && g < 100) begin
      idle();
      g++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    idle();
    idle();
    #1;
    chk("drain_out_pvld", out_pvld, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
